// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner.
// Walks an active-low column strobe across the keypad, debounces the single
// key it finds, and reports its hex code with a one-cycle trig pulse.
// A held key produces exactly one trig; a full release debounce must complete
// before scanning resumes and another key can be accepted.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  SCAN     | stepping columns on each tick, looking for one low row
//  DEBOUNCE | column frozen, counting ticks with the same row pattern
//  PRESSED  | key accepted, waiting for all rows to return high
//  RELEASE  | rows high, counting idle ticks before resuming the scan
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] value_o,
    output logic       trig_o,
    output logic       pressed_o
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DCNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_TERM = DCNT_W'(DEBOUNCE_CNT);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = '0;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        row_s1_q, row_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        idx_q, idx_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [3:0]        cap_q, cap_d;
    logic [3:0]        value_q, value_d;
    logic              trig_q, trig_d;

    logic [3:0]        rs;
    logic [3:0]        rows_low;
    logic              tick;
    logic              sample_valid;
    logic              rows_idle;
    logic [DCNT_W-1:0] dcnt_inc;
    logic              dcnt_done;

    // Map the captured low-row pattern and the frozen column to the key code.
    function automatic logic [3:0] key_code(input logic [3:0] low, input logic [1:0] c);
        logic [1:0] r;
        logic [3:0] code;
        r = 2'd0;
        unique case (low)
            4'b0001: r = 2'd0;
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        unique case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines; idles at all-high.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_i;
            row_s2_q <= row_s1_q;
        end
    end

    assign rs = row_s2_q;

    // Free-running dwell divider; tick paces every FSM decision.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Divider register, independent of the FSM state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Row pattern classification; two or more low rows count as idle.
    always_comb begin
        rows_low     = ~rs;
        sample_valid = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'h1)) == 4'h0);
        rows_idle    = (rs == 4'hF);
        dcnt_inc     = (dcnt_q == DCNT_TERM) ? dcnt_q : dcnt_q + DCNT_ONE;
        dcnt_done    = (dcnt_inc == DCNT_TERM);
    end

    // Next-state and datapath updates, evaluated only on tick.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        cap_d   = cap_q;
        value_d = value_q;
        trig_d  = 1'b0;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (sample_valid) begin
                        cap_d   = rs;
                        dcnt_d  = DCNT_ONE;
                        state_d = DEBOUNCE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rs == cap_q) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_done) begin
                            state_d = PRESSED;
                            value_d = key_code(~cap_q, idx_q);
                            trig_d  = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + 2'd1;
                        dcnt_d  = DCNT_ZERO;
                    end
                end
                PRESSED: begin
                    // Any other low pattern, including another key in this
                    // column, simply keeps the key held.
                    if (rows_idle) begin
                        state_d = RELEASE;
                        dcnt_d  = DCNT_ONE;
                    end
                end
                RELEASE: begin
                    if (rows_idle) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_done) begin
                            state_d = SCAN;
                            idx_d   = idx_q + 2'd1;
                            dcnt_d  = DCNT_ZERO;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    // FSM and datapath registers; reset aborts any press without a trig.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SCAN;
            idx_q   <= 2'd0;
            dcnt_q  <= DCNT_ZERO;
            cap_q   <= 4'hF;
            value_q <= 4'h0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            cap_q   <= cap_d;
            value_q <= value_d;
            trig_q  <= trig_d;
        end
    end

    assign col_o     = ~(4'b0001 << idx_q);
    assign value_o   = value_q;
    assign trig_o    = trig_q;
    assign pressed_o = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A small keypad model pulls a row low only while its key's column is driven.
module tb_keypad_scan;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] value;
    logic       trig;
    logic       pressed;

    logic       ka_dn, kb_dn;
    logic [1:0] ka_r, ka_c, kb_r, kb_c;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;

    logic [3:0] cols_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .row_i     (row),
        .col_o     (col),
        .value_o   (value),
        .trig_o    (trig),
        .pressed_o (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a held key shorts its row to its column strobe.
    always_comb begin
        row = 4'hF;
        if (ka_dn && !col[ka_c]) row[ka_r] = 1'b0;
        if (kb_dn && !col[kb_c]) row[kb_r] = 1'b0;
    end

    // Count trig pulses over the whole run.
    always @(posedge clk) begin
        if (trig === 1'b1) trig_cnt <= trig_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Return at the first negedge after col switches to target.
    task automatic wait_col(input logic [3:0] target);
        logic [3:0] prev;
        int found;
        prev  = col;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (col == target && prev != target) found = 1;
            prev = col;
        end
        check("wait_col", found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int seen;
        int found;

        reset = 1'b1;
        ka_dn = 1'b0; kb_dn = 1'b0;
        ka_r = 2'd0; ka_c = 2'd0; kb_r = 2'd0; kb_c = 2'd0;

        repeat (2) @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_value", value, 4'h0);
        check("rst_trig", trig, 1'b0);
        check("rst_pressed", pressed, 1'b0);
        reset = 1'b0;

        // Idle scan: column steps every 4 cycles starting from column 0.
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check("idle_col", col, cols_tbl[(k / 4) % 4]);
        end
        check("idle_trig_cnt", trig_cnt, 0);
        check("idle_value", value, 4'h0);

        // Key (row0, col1) -> 2, single trig on the third matching tick.
        wait_col(4'b1101);
        ka_r = 2'd0; ka_c = 2'd1; ka_dn = 1'b1;
        t0 = trig_cnt;
        repeat (5) @(negedge clk);
        check("deb_col_frozen", col, 4'b1101);
        check("deb_pressed", pressed, 1'b0);
        repeat (6) @(negedge clk);
        check("pre_trig", trig, 1'b0);
        check("pre_pressed", pressed, 1'b0);
        @(negedge clk);
        check("k2_trig", trig, 1'b1);
        check("k2_value", value, 4'h2);
        check("k2_pressed", pressed, 1'b1);
        @(negedge clk);
        check("k2_trig_one", trig, 1'b0);

        // Hold for 200 cycles; a second key in the same column is ignored.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 100) begin kb_r = 2'd1; kb_c = 2'd1; kb_dn = 1'b1; end
            if (i == 150) kb_dn = 1'b0;
        end
        check("hold_trig_cnt", trig_cnt - t0, 1);
        check("hold_value", value, 4'h2);
        check("hold_pressed", pressed, 1'b1);
        check("hold_col", col, 4'b1101);

        // Release: three idle ticks, then scanning resumes at column 2.
        ka_dn = 1'b0;
        repeat (10) @(negedge clk);
        check("rel_pressed", pressed, 1'b1);
        check("rel_col", col, 4'b1101);
        @(negedge clk);
        check("rel_done_pressed", pressed, 1'b0);
        check("rel_done_col", col, 4'b1011);

        // Bounce on key (row3, col3): glitch aborts, real press gives D.
        wait_col(4'b0111);
        ka_r = 2'd3; ka_c = 2'd3; ka_dn = 1'b1;
        t0 = trig_cnt;
        repeat (4) @(negedge clk);
        check("bnc_frozen", col, 4'b0111);
        ka_dn = 1'b0;
        repeat (4) @(negedge clk);
        check("bnc_abort_col", col, 4'b1110);
        check("bnc_abort_pressed", pressed, 1'b0);
        ka_dn = 1'b1;
        repeat (23) @(negedge clk);
        check("bnc_no_trig_cnt", trig_cnt - t0, 0);
        check("bnc_no_trig", trig, 1'b0);
        check("bnc_col", col, 4'b0111);
        @(negedge clk);
        check("kD_trig", trig, 1'b1);
        check("kD_value", value, 4'hD);
        ka_dn = 1'b0;
        repeat (16) @(negedge clk);
        check("kD_released", pressed, 1'b0);
        check("kD_resume_col", col, 4'b1101);
        check("kD_trig_cnt", trig_cnt - t0, 1);

        // Two rows low in one column: invalid, never debounced.
        wait_col(4'b1011);
        ka_r = 2'd0; ka_c = 2'd2; ka_dn = 1'b1;
        kb_r = 2'd1; kb_c = 2'd2; kb_dn = 1'b1;
        t0 = trig_cnt;
        seen = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pressed === 1'b1) seen = 1;
        end
        check("multi_pressed_seen", seen, 0);
        check("multi_trig_cnt", trig_cnt - t0, 0);
        check("multi_col", col, 4'b1011);
        ka_dn = 1'b0; kb_dn = 1'b0;

        // Key (row2, col2) -> 9, then reset while held.
        wait_col(4'b1011);
        ka_r = 2'd2; ka_c = 2'd2; ka_dn = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (trig === 1'b1) found = 1;
        end
        check("k9_found", found, 1);
        check("k9_value", value, 4'h9);
        check("k9_pressed", pressed, 1'b1);
        @(negedge clk);
        t0 = trig_cnt;
        #2 reset = 1'b1;
        #1;
        check("arst_col", col, 4'b1110);
        check("arst_pressed", pressed, 1'b0);
        check("arst_value", value, 4'h0);
        check("arst_trig", trig, 1'b0);
        ka_dn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_col0", col, 4'b1110);
        @(negedge clk);
        check("post_rst_col1", col, 4'b1101);
        check("post_rst_trig_cnt", trig_cnt - t0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per column dwell (1 ms at 50 MHz); legal range >= 4.
REQ-002 Parameter DEBOUNCE_CNT, default 10, consecutive matching dwell samples required to accept a press or a release; legal range >= 2.
REQ-003 clk  input  1  system clock; the block uses this single clock domain, and all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  column drive, active-low one-hot; exactly one bit low at all times.
REQ-007 value  output  4  hex code of the last accepted key; held until the next accepted key.
REQ-008 trig  output  1  one-cycle pulse per accepted press; feeds the shift-register stage.
REQ-009 pressed  output  1  high while a debounced key is held (PRESSED or RELEASE state).

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-011 Divider: counts 0..SCAN_DIV-1 and wraps; tick = (count == SCAN_DIV-1); free-running in all states.
REQ-012 Column index 0..3 drives col = ~(4'b0001 << idx); idx advances only where stated below, wrapping 3->0.
REQ-013 Valid sample: rs has exactly one bit low; zero low bits = idle; two or more low bits = invalid, treated as idle.
REQ-014 Key map (row r, col c -> value): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D.
REQ-015 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE; transitions are evaluated only on tick.
REQ-016 SCAN: valid sample -> capture rs and idx, set dcnt=1, go to DEBOUNCE, hold idx; otherwise advance idx.
REQ-017 DEBOUNCE: rs == captured -> dcnt+1; when dcnt+1 == DEBOUNCE_CNT -> go to PRESSED, load value from the map; rs != captured -> go to SCAN, advance idx, clear dcnt.
REQ-018 trig SHALL be high in exactly the one cycle after the DEBOUNCE->PRESSED edge, with value already updated in that cycle.
REQ-019 PRESSED: rs all-high -> go to RELEASE, dcnt=1; otherwise stay. Changes of key within the same column SHALL be ignored and produce no trig.
REQ-020 RELEASE: rs all-high -> dcnt+1; when it reaches DEBOUNCE_CNT -> go to SCAN and advance idx; any low bit -> return to PRESSED with no trig.
REQ-021 col SHALL stay constant from DEBOUNCE entry until RELEASE exits.
REQ-022 dcnt width SHALL be clog2(DEBOUNCE_CNT+1) and SHALL saturate, never wrap.
REQ-023 A new trig requires a full release-debounce first; holding a key yields exactly one trig.

Reset
REQ-024 On reset assertion, asynchronously: state=SCAN, idx=0, col=4'b1110, value=0, trig=0, pressed=0, divider=0, dcnt=0, synchronizer flops=4'b1111.
REQ-025 Reset asserted mid-press SHALL abort without a trig; after release of reset, scanning restarts at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-026 Idle rows=1111 for 64 cycles -> col cycles 1110,1101,1011,0111 every 4 cycles; trig never high.
REQ-027 Hold row0 low while col=1101 -> DEBOUNCE, col frozen; trig is a single pulse with value=2 in the cycle after the third matching tick; pressed=1.
REQ-028 Same press held for 200 cycles -> exactly one trig; release -> pressed falls and scanning resumes at col=1011 after 3 idle ticks.
REQ-029 Bounce: row3 low at col=0111 for 1 tick, high 1 tick, then low -> no trig from the first glitch; trig with value=D only after 3 consecutive matching ticks.
REQ-030 Two rows low together (rows 0 and 1) -> no DEBOUNCE entry, no trig; reset asserted in PRESSED -> col=1110, pressed=0, value=0 immediately, without waiting for a clock edge.
